// File: rtl/bit_encoder_stream_pkg.sv
// Shared types and sizes for the set-bit index streamer.
// The state enum, vector/index widths and a one-hot mask helper live here.
package bit_encoder_stream_pkg;

    localparam int N_BITS = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [N_BITS-1:0] bitMask(input logic [IDX_W-1:0] idx);
        logic [N_BITS-1:0] mask;
        mask = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/bit_encoder_stream_prio_enc8.sv
// Combinational 8-bit priority encoder with selectable search direction.
// o_any flags a non-empty vector; o_idx is 0 when the vector is empty.
module prio_enc8
    import bit_encoder_stream_pkg::*;
(
    input  logic [N_BITS-1:0] i_vec,
    input  logic              i_lsb_first,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // Scan so that the winning bit is the last one assigned.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = 0; i < N_BITS; i++) begin
            if (i_lsb_first) begin
                if (i_vec[N_BITS-1-i]) begin
                    o_idx = IDX_W'(N_BITS-1-i);
                end
            end else begin
                if (i_vec[i]) begin
                    o_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bit_encoder_stream.sv
// Captures a request vector and streams out the index of each set bit in
// priority order over a valid/ready handshake; all outputs are registered.
module bit_encoder_stream
    import bit_encoder_stream_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] req,
    input  logic              load,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  idx,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              zero_err
);

    state_t             r_state;
    logic [N_BITS-1:0]  r_pending;
    logic [IDX_W-1:0]   r_idx;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_zero_err;

    logic [N_BITS-1:0]  w_next_pending;
    logic [IDX_W-1:0]   w_enc_idx;
    logic               w_enc_any;
    logic               w_lsb_first;

    assign w_lsb_first = LSB_FIRST;

    // The encoder looks at next cycle's pending bits so idx can be registered.
    always_comb begin
        w_next_pending = r_pending;
        if (r_state == IDLE) begin
            if (load && (req != '0)) begin
                w_next_pending = req;
            end
        end else if (out_ready) begin
            w_next_pending = r_pending & ~bitMask(r_idx);
        end
    end

    prio_enc8 u_prio_enc8 (
        .i_vec       (w_next_pending),
        .i_lsb_first (w_lsb_first),
        .o_idx       (w_enc_idx),
        .o_any       (w_enc_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_zero_err  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_zero_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        if (req != '0) begin
                            r_pending   <= w_next_pending;
                            r_idx       <= w_enc_idx;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= EMIT;
                        end else begin
                            r_zero_err <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // load is deliberately not examined while emitting.
                    if (out_ready) begin
                        r_pending <= w_next_pending;
                        if (w_enc_any) begin
                            r_idx <= w_enc_idx;
                        end else begin
                            r_idx       <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign idx       = r_idx;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign zero_err  = r_zero_err;

endmodule

// File: tb/tb_bit_encoder_stream.sv
// Drives an LSB-first and an MSB-first instance with identical stimulus and
// compares both against fixed vectors and a queue-based reference model.
module tb_bit_encoder_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       out_ready;
    logic [7:0] req;

    logic [2:0] idxL, idxM;
    logic       validL, validM, busyL, busyM, doneL, doneM, zerrL, zerrM;

    int checks = 0;
    int errors = 0;

    // Expected emission order for each direction; empty means idle.
    int qL[$];
    int qM[$];
    bit mDoneL, mDoneM, mZerr;

    typedef struct {
        bit       rst;
        bit       load;
        bit       ready;
        bit [7:0] req;
        int       expIdxL;
        int       expIdxM;
        bit       expValid;
        bit       expBusy;
        bit       expDone;
        bit       expZerr;
    } vec_t;

    vec_t table_[8];

    always #5 clk = ~clk;

    bit_encoder_stream #(.LSB_FIRST(1'b1)) dutL (
        .clk(clk), .rst(rst), .req(req), .load(load), .out_ready(out_ready),
        .idx(idxL), .out_valid(validL), .busy(busyL), .done(doneL), .zero_err(zerrL)
    );

    bit_encoder_stream #(.LSB_FIRST(1'b0)) dutM (
        .clk(clk), .rst(rst), .req(req), .load(load), .out_ready(out_ready),
        .idx(idxM), .out_valid(validM), .busy(busyM), .done(doneM), .zero_err(zerrM)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference behaviour evaluated at each rising edge from the sampled inputs.
    task automatic modelStep();
        mDoneL = 1'b0;
        mDoneM = 1'b0;
        mZerr  = 1'b0;
        if (rst) begin
            qL.delete();
            qM.delete();
        end else if (qL.size() == 0) begin
            if (load) begin
                if (req == 8'h00) begin
                    mZerr = 1'b1;
                end else begin
                    for (int i = 0; i < 8; i++) if (req[i]) qL.push_back(i);
                    for (int i = 7; i >= 0; i--) if (req[i]) qM.push_back(i);
                end
            end
        end else if (out_ready) begin
            void'(qL.pop_front());
            void'(qM.pop_front());
            if (qL.size() == 0) mDoneL = 1'b1;
            if (qM.size() == 0) mDoneM = 1'b1;
        end
    endtask

    task automatic checkModel();
        checkOutput("L.idx",      idxL,   (qL.size() != 0) ? qL[0] : 0);
        checkOutput("L.out_valid", validL, qL.size() != 0);
        checkOutput("L.busy",     busyL,  qL.size() != 0);
        checkOutput("L.done",     doneL,  mDoneL);
        checkOutput("L.zero_err", zerrL,  mZerr);
        checkOutput("M.idx",      idxM,   (qM.size() != 0) ? qM[0] : 0);
        checkOutput("M.out_valid", validM, qM.size() != 0);
        checkOutput("M.busy",     busyM,  qM.size() != 0);
        checkOutput("M.done",     doneM,  mDoneM);
        checkOutput("M.zero_err", zerrM,  mZerr);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkModel();
    endtask

    task automatic applyStimulus(input bit rs, input bit ld, input bit rd, input logic [7:0] r);
        rst       = rs;
        load      = ld;
        out_ready = rd;
        req       = r;
        tick();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; out_ready = 1'b0; req = 8'h00;

        //             rst  load rdy  req    iL iM vld bsy don zer
        table_[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 0, 0, 0, 0, 0, 0};
        table_[1] = '{1'b0, 1'b1, 1'b1, 8'hA4, 2, 7, 1, 1, 0, 0};
        table_[2] = '{1'b0, 1'b0, 1'b1, 8'h00, 5, 5, 1, 1, 0, 0};
        table_[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 7, 2, 1, 1, 0, 0};
        table_[4] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 0, 0, 0, 1, 0};
        table_[5] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 0, 0, 0, 0, 0};
        table_[6] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 0, 0, 0, 0, 1};
        table_[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 8; i++) begin
            applyStimulus(table_[i].rst, table_[i].load, table_[i].ready, table_[i].req);
            checkOutput($sformatf("tbl%0d.idxL", i),  idxL,   table_[i].expIdxL);
            checkOutput($sformatf("tbl%0d.idxM", i),  idxM,   table_[i].expIdxM);
            checkOutput($sformatf("tbl%0d.valid", i), validL, table_[i].expValid);
            checkOutput($sformatf("tbl%0d.busy", i),  busyM,  table_[i].expBusy);
            checkOutput($sformatf("tbl%0d.done", i),  doneL,  table_[i].expDone);
            checkOutput($sformatf("tbl%0d.zerr", i),  zerrM,  table_[i].expZerr);
        end

        // Stalled consumer: 8'h81 held for four cycles, then drained.
        applyStimulus(0, 1, 0, 8'h81);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 8'h00);
            checkOutput("stall.idxL", idxL, 0);
            checkOutput("stall.idxM", idxM, 7);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h00);

        // Reset after three transfers of 8'hFF, then a fresh single-bit load.
        applyStimulus(0, 1, 1, 8'hFF);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h00);
        applyStimulus(1, 1, 1, 8'h3C);
        checkOutput("rstmid.doneL", doneL, 0);
        checkOutput("rstmid.validL", validL, 0);
        applyStimulus(0, 1, 1, 8'h10);
        checkOutput("post.idxL", idxL, 4);
        checkOutput("post.idxM", idxM, 4);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 8'h00);

        // Load pulsed mid-emission, then a load coinciding with the last transfer.
        applyStimulus(0, 1, 0, 8'h06);
        applyStimulus(0, 1, 1, 8'hF0);
        applyStimulus(0, 1, 1, 8'hF0);
        checkOutput("ignored.doneL", doneL, 1);
        checkOutput("ignored.busyL", busyL, 0);
        applyStimulus(0, 0, 1, 8'h00);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 59) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
